// File: rtl/pmem_write_buffer_if.sv
// Line-granular request/response port shared by the arbiter side and the
// physical memory side of the write buffer. The requester drives address,
// read, write and wdata; the responder returns a one-cycle resp with rdata.
interface pmem_write_buffer_if;
  logic [15:0]  address;
  logic         read;
  logic         write;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;

  modport master (
    output address, read, write, wdata,
    input  resp, rdata
  );

  modport slave (
    input  address, read, write, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/pmem_write_buffer.sv
// Write-back buffer between the arbiter's downstream port and physical memory.
// Evicted lines are absorbed in one cycle into a small circular FIFO and
// drained to memory in the background. Reads that hit a buffered line are
// served from the youngest copy; misses go to physical memory through FILL,
// but only once any drain already in flight has completed.
module pmem_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  pmem_write_buffer_if.slave  mem,
  pmem_write_buffer_if.master pmem
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Buffered lines; the valid bit marks occupancy, tag is the line index.
  logic [DEPTH-1:0] valid_reg;
  logic [11:0]      tag_reg  [DEPTH];
  logic [127:0]     data_reg [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  logic             resp_reg;
  logic [127:0]     rdata_reg;
  logic [11:0]      fill_line_reg;

  logic [DEPTH-1:0] match;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] scan_idx;

  logic             req_ok;
  logic             wr_accept;
  logic             rd_hit;
  logic             rd_miss;
  logic             dequeue;
  logic             fill_done;

  // Only whole lines are buffered, so the byte offset plays no part.
  logic             addr_offset_unused;
  assign addr_offset_unused = ^mem.address[3:0];

  // Per-entry tag compare against the upstream line index.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (tag_reg[gi] == mem.address[15:4]);
  end

  // Scan from oldest to youngest so the last match found is the newest copy.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_reg + PTR_W'(i);
      if (match[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  // Request qualification: nothing is accepted while a response is showing.
  always_comb begin
    req_ok    = !resp_reg;
    wr_accept = req_ok && mem.write && (count_reg != FULL_COUNT);
    rd_hit    = req_ok && mem.read && hit && (state_reg != FILL);
    rd_miss   = req_ok && mem.read && !hit;
    dequeue   = (state_reg == DRAIN) && pmem.resp;
    fill_done = (state_reg == FILL) && pmem.resp;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and physical-side outputs, decoded purely from registered state.
  always_comb begin
    state_next   = state_reg;
    pmem.read    = 1'b0;
    pmem.write   = 1'b0;
    pmem.address = 16'h0000;
    pmem.wdata   = '0;
    case (state_reg)
      IDLE: begin
        if (rd_miss) begin
          state_next = FILL;
        end else if (count_reg != '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        pmem.write   = 1'b1;
        pmem.address = {tag_reg[head_reg], 4'b0000};
        pmem.wdata   = data_reg[head_reg];
        if (pmem.resp) begin
          state_next = IDLE;
        end
      end
      FILL: begin
        pmem.read    = 1'b1;
        pmem.address = {fill_line_reg, 4'b0000};
        if (pmem.resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the missing line when FILL is entered so pmem.address is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_line_reg <= '0;
    end else if ((state_reg == IDLE) && rd_miss) begin
      fill_line_reg <= mem.address[15:4];
    end
  end

  // Occupancy bits: cleared on dequeue at head, set on enqueue at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      if (dequeue) begin
        valid_reg[head_reg] <= 1'b0;
      end
      if (wr_accept) begin
        valid_reg[tail_reg] <= 1'b1;
      end
    end
  end

  // Line storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      tag_reg[tail_reg]  <= mem.address[15:4];
      data_reg[tail_reg] <= mem.wdata;
    end
  end

  // FIFO pointers and occupancy count; enqueue plus dequeue nets to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_accept) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (dequeue) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({wr_accept, dequeue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Upstream response: one-cycle pulse with the hit line or the filled line.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      resp_reg <= wr_accept || rd_hit || fill_done;
      if (rd_hit) begin
        rdata_reg <= data_reg[hit_idx];
      end else if (fill_done) begin
        rdata_reg <= pmem.rdata;
      end
    end
  end

  assign mem.resp  = resp_reg;
  assign mem.rdata = rdata_reg;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer: hand-written sequences for reset,
// drain, stall, miss-behind-drain and reset-during-fill, then a vector table
// run against an automatic physical memory responder with a backing store.
module tb_pmem_write_buffer;

  localparam int AUTO_LAT = 20;

  localparam logic [127:0] DA    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DB    = 128'hbbbb_0000_bbbb_1111_bbbb_2222_bbbb_3333;
  localparam logic [127:0] DC    = 128'hcccc_dddd_eeee_ffff_0123_4567_89ab_cdef;
  localparam logic [127:0] DD    = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
  localparam logic [127:0] DZ    = 128'h4000_0000_0000_0000_0000_0000_0000_4444;
  localparam logic [127:0] DX    = 128'h5000_5000_5000_5000_0000_0000_0000_0005;
  localparam logic [127:0] DY    = 128'h6000_6000_6000_6000_0000_0000_0000_0006;
  localparam logic [127:0] DR    = 128'hfeed_face_0000_1111_2222_3333_5555_5550;
  localparam logic [127:0] P7770 = 128'h7770_7770_7770_7770_7770_7770_7770_7770;

  typedef struct {
    bit           is_wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    int           exp_lat;   // 0 = latency not checked
    int           exp_rd;    // 0 = no pmem read, 1 = pmem read, 2 = not checked
    int           gap;       // idle cycles before the request
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pmem_write_buffer_if mem_if ();
  pmem_write_buffer_if pmem_if ();

  pmem_write_buffer #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem_if),
    .pmem  (pmem_if)
  );

  int checks = 0;
  int errors = 0;

  logic         auto_en    = 1'b0;
  logic         auto_resp  = 1'b0;
  logic [127:0] auto_rdata = '0;
  logic         man_resp   = 1'b0;
  logic [127:0] man_rdata  = '0;
  int           wait_cnt   = 0;
  int           pmem_read_cycles = 0;
  int           resp_pulses = 0;
  logic [127:0] mem_model [logic [11:0]];

  assign pmem_if.resp  = auto_resp | man_resp;
  assign pmem_if.rdata = auto_en ? auto_rdata : man_rdata;

  always @(posedge clk) begin
    if (pmem_if.read) pmem_read_cycles <= pmem_read_cycles + 1;
    if (mem_if.resp)  resp_pulses <= resp_pulses + 1;
  end

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {8{a}};
  endfunction

  // Automatic physical memory: answers after AUTO_LAT cycles, stores writes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_resp) begin
        auto_resp = 1'b0;
      end else if (auto_en && (pmem_if.read || pmem_if.write)) begin
        if (wait_cnt >= AUTO_LAT) begin
          wait_cnt  = 0;
          auto_resp = 1'b1;
          if (pmem_if.write) begin
            mem_model[pmem_if.address[15:4]] = pmem_if.wdata;
          end else if (mem_model.exists(pmem_if.address[15:4])) begin
            auto_rdata = mem_model[pmem_if.address[15:4]];
          end else begin
            auto_rdata = pat(pmem_if.address);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit is_wr, input logic [15:0] addr, input logic [127:0] wd,
                        output int lat, output logic [127:0] rd);
    mem_if.address = addr;
    mem_if.wdata   = wd;
    mem_if.write   = is_wr;
    mem_if.read    = !is_wr;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mem_if.resp && lat < 500);
    if (!mem_if.resp) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %h got no resp, expected resp within 500 cycles", addr);
    end
    rd = mem_if.rdata;
    mem_if.read  = 1'b0;
    mem_if.write = 1'b0;
    tick();
    check("resp_width", {127'd0, mem_if.resp}, 128'd0);
    $display("%s addr=%h lat=%0d rdata=%h", is_wr ? "WR" : "RD", addr, lat, rd);
  endtask

  task automatic wait_pmem(input bit want_wr, input int limit);
    int n;
    n = 0;
    while (!(want_wr ? pmem_if.write : pmem_if.read) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (!(want_wr ? pmem_if.write : pmem_if.read)) begin
      errors++;
      $display("FAIL pmem_%s_timeout: got no request, expected one within %0d cycles",
               want_wr ? "write" : "read", limit);
    end
  endtask

  task automatic pulse_man_resp(input logic [127:0] rd);
    man_rdata = rd;
    man_resp  = 1'b1;
    tick();
    man_resp  = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    int lat;
    int rc0;
    int snap;
    logic [127:0] rd;

    vecs[0]  = '{1'b1, 16'h2000, DA,     128'd0, 1, 0, 0};
    vecs[1]  = '{1'b1, 16'h2000, DB,     128'd0, 1, 0, 0};
    vecs[2]  = '{1'b0, 16'h2008, 128'd0, DB,     1, 0, 0};
    vecs[3]  = '{1'b0, 16'h200F, 128'd0, DB,     1, 0, 0};
    vecs[4]  = '{1'b0, 16'h7770, 128'd0, P7770,  0, 1, 0};
    vecs[5]  = '{1'b1, 16'h3010, DC,     128'd0, 1, 0, 0};
    vecs[6]  = '{1'b0, 16'h3010, 128'd0, DC,     1, 0, 0};
    vecs[7]  = '{1'b0, 16'h2000, 128'd0, DB,     0, 2, 0};
    vecs[8]  = '{1'b0, 16'h3010, 128'd0, DC,     0, 1, 100};
    vecs[9]  = '{1'b0, 16'h2000, 128'd0, DB,     0, 1, 0};
    vecs[10] = '{1'b1, 16'h4440, DD,     128'd0, 1, 0, 0};
    vecs[11] = '{1'b0, 16'h4440, 128'd0, DD,     1, 0, 0};

    mem_if.address = '0;
    mem_if.wdata   = '0;
    mem_if.read    = 1'b0;
    mem_if.write   = 1'b0;

    // Reset, then five idle cycles.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_mem_resp",   {127'd0, mem_if.resp},   128'd0);
    check("rst_mem_rdata",  mem_if.rdata,            128'd0);
    check("rst_pmem_read",  {127'd0, pmem_if.read},  128'd0);
    check("rst_pmem_write", {127'd0, pmem_if.write}, 128'd0);
    check("rst_pmem_addr",  {112'd0, pmem_if.address}, 128'd0);
    check("rst_pmem_wdata", pmem_if.wdata,           128'd0);
    check("rst_count",      {125'd0, dut.count_reg}, 128'd0);
    $display("RESET idle checks done");

    // Single write drains to 0x1230 with the written data.
    do_req(1'b1, 16'h1230, DA, lat, rd);
    check("wr_lat", lat, 1);
    wait_pmem(1'b1, 10);
    check("drain_addr", {112'd0, pmem_if.address}, {112'd0, 16'h1230});
    check("drain_data", pmem_if.wdata, DA);
    repeat (2) tick();
    check("drain_hold_write", {127'd0, pmem_if.write}, 128'd1);
    check("drain_hold_addr",  {112'd0, pmem_if.address}, {112'd0, 16'h1230});
    pulse_man_resp(128'd0);
    check("drain_done_write", {127'd0, pmem_if.write}, 128'd0);
    check("drain_done_count", {125'd0, dut.count_reg}, 128'd0);

    // Full buffer with stalled memory: the third write waits for a dequeue.
    do_req(1'b1, 16'h5000, DX, lat, rd);
    check("fill1_lat", lat, 1);
    do_req(1'b1, 16'h6000, DY, lat, rd);
    check("fill2_lat", lat, 1);
    mem_if.address = 16'h4000;
    mem_if.wdata   = DZ;
    mem_if.write   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_resp_%0d", i), {127'd0, mem_if.resp}, 128'd0);
    end
    check("stall_drain_addr", {112'd0, pmem_if.address}, {112'd0, 16'h5000});
    pulse_man_resp(128'd0);
    check("stall_no_resp_on_deq", {127'd0, mem_if.resp}, 128'd0);
    tick();
    check("stall_accept_resp", {127'd0, mem_if.resp}, 128'd1);
    mem_if.write = 1'b0;
    tick();
    $display("WR addr=4000 accepted after stall");
    wait_pmem(1'b1, 10);
    check("drain2_addr", {112'd0, pmem_if.address}, {112'd0, 16'h6000});
    check("drain2_data", pmem_if.wdata, DY);
    pulse_man_resp(128'd0);
    wait_pmem(1'b1, 10);
    check("drain3_addr", {112'd0, pmem_if.address}, {112'd0, 16'h4000});
    check("drain3_data", pmem_if.wdata, DZ);
    pulse_man_resp(128'd0);
    tick();
    check("stall_end_count", {125'd0, dut.count_reg}, 128'd0);

    // Read miss arriving while a drain is in flight.
    do_req(1'b1, 16'h1230, DA, lat, rd);
    wait_pmem(1'b1, 10);
    mem_if.address = 16'h5550;
    mem_if.read    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("miss_wait_read_%0d", i), {127'd0, pmem_if.read}, 128'd0);
    end
    pulse_man_resp(128'd0);
    check("miss_gap_write", {127'd0, pmem_if.write}, 128'd0);
    check("miss_gap_read",  {127'd0, pmem_if.read},  128'd0);
    tick();
    check("miss_fill_read", {127'd0, pmem_if.read}, 128'd1);
    check("miss_fill_addr", {112'd0, pmem_if.address}, {112'd0, 16'h5550});
    tick();
    check("miss_fill_hold", {112'd0, pmem_if.address}, {112'd0, 16'h5550});
    pulse_man_resp(DR);
    check("miss_resp",  {127'd0, mem_if.resp}, 128'd1);
    check("miss_rdata", mem_if.rdata, DR);
    mem_if.read = 1'b0;
    tick();
    check("miss_resp_width", {127'd0, mem_if.resp}, 128'd0);
    $display("RD addr=5550 rdata=%h after drain", DR);

    // Reset while a fill is outstanding.
    mem_if.address = 16'h9990;
    mem_if.read    = 1'b1;
    tick();
    check("rstfill_read_on", {127'd0, pmem_if.read}, 128'd1);
    tick();
    snap  = resp_pulses;
    reset = 1'b1;
    tick();
    check("rstfill_read_off", {127'd0, pmem_if.read}, 128'd0);
    reset = 1'b0;
    mem_if.read = 1'b0;
    repeat (5) tick();
    check("rstfill_no_resp", resp_pulses, snap);
    check("rstfill_count",   {125'd0, dut.count_reg}, 128'd0);
    check("rstfill_rdata",   mem_if.rdata, 128'd0);
    $display("RESET during fill checks done");

    // Vector table against the automatic memory.
    auto_en = 1'b1;
    for (int v = 0; v < 12; v++) begin
      repeat (vecs[v].gap) tick();
      rc0 = pmem_read_cycles;
      do_req(vecs[v].is_wr, vecs[v].addr, vecs[v].wdata, lat, rd);
      if (vecs[v].exp_lat != 0)
        check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      if (!vecs[v].is_wr)
        check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      if (vecs[v].exp_rd != 2)
        check($sformatf("vec%0d_pmem_read", v), (pmem_read_cycles != rc0) ? 1 : 0,
              vecs[v].exp_rd);
    end
    repeat (100) tick();
    check("final_count", {125'd0, dut.count_reg}, 128'd0);
    check("final_pmem_write", {127'd0, pmem_if.write}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_write_buffer.md
# pmem_write_buffer

Write-back buffer between the memory arbiter's shared downstream port and physical memory. Absorbs cache-line writes (evictions) from the arbiter in one cycle and drains them to physical memory in the background. Forwards read hits from buffered lines and services read misses directly from physical memory. To the arbiter it presents a single read/write/resp port; to physical memory it presents the same protocol.

## Interface
- DEPTH, 2, number of buffered lines; power of two, ≥ 2.

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_address  in  16  upstream byte address; line index = bits [15:4]
- mem_read  in  1  upstream read request, held until mem_resp
- mem_write  in  1  upstream write request, held until mem_resp
- mem_wdata  in  128  upstream write line
- mem_resp  out  1  one-cycle completion pulse to upstream
- mem_rdata  out  128  read line; valid while mem_resp = 1
- pmem_address  out  16  physical memory address, line aligned ([3:0] = 0)
- pmem_read  out  1  physical read request
- pmem_write  out  1  physical write request
- pmem_wdata  out  128  physical write line
- pmem_resp  in  1  physical completion pulse
- pmem_rdata  in  128  physical read line, valid with pmem_resp

## Operation
- Storage: DEPTH entries {valid, tag[11:0], data[127:0]}, circular FIFO with head/tail pointers and a count of 0..DEPTH.
- Pointers wrap modulo DEPTH.
- mem_read and mem_write are never both high; this is an upstream guarantee and is not checked.
- Acceptance: a request is accepted only when mem_resp is not pending.
  - In the cycle mem_resp = 1, upstream requests are ignored.
  - Requests are evaluated combinationally against the current buffer contents.
- Write, count < DEPTH: enqueue {tag, mem_wdata} at tail. No merging; duplicate tags are allowed.
- Write, count = DEPTH: stall (no resp). Accept in the first cycle count < DEPTH; a dequeue this cycle frees space only from the next cycle.
- Read hit (tag matches a valid entry): return data of the youngest matching entry. Accepted in any state except FILL.
- Read miss: issue a physical read via the FILL state. Never forwarded while a drain is in flight; it waits for DRAIN to finish.
- Controller states:
  - IDLE: pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
    - Read miss pending → FILL.
    - Else if count > 0 → DRAIN.
    - A write accepted this cycle makes count > 0 next cycle. Read misses have priority over starting a drain.
  - DRAIN: pmem_write = 1, pmem_address = {head tag, 4'b0}, pmem_wdata = head data.
    - On pmem_resp: dequeue head, → IDLE.
    - Upstream writes may enqueue and read hits are served during DRAIN. The head stays valid and hittable until dequeued.
  - FILL: pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}.
    - On pmem_resp: capture pmem_rdata into mem_rdata, schedule mem_resp, → IDLE.
- A write and a dequeue in the same cycle update count by net 0.
- Reset: all entries invalid, count = 0, pointers = 0, state IDLE, mem_resp = 0, mem_rdata = 0, all pmem outputs 0.
  - Reset mid-DRAIN or mid-FILL abandons the transaction; buffered writes are lost.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from mem_* inputs to pmem_* outputs.
- Write accept or read hit: request accepted in cycle t → mem_resp = 1 in cycle t+1 (latency 1).
- Read miss from IDLE with no drain:
  - Request in cycle t → FILL entered, pmem_read = 1 from cycle t+1.
  - pmem_resp in cycle p → mem_resp in cycle p+1.
- Read miss during DRAIN: pmem_write drops the cycle after pmem_resp, then IDLE lasts one cycle, then FILL.
- Drain start: the first write accepted in IDLE at cycle t gives pmem_write = 1 no earlier than cycle t+2 (IDLE at t+1 sees count = 1).
- mem_resp is exactly one cycle wide. pmem_read and pmem_write are held until pmem_resp, with address and data stable.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, count 0.
- Write 0x1230 with data A → mem_resp at t+1; pmem_write with address 0x1230 and data A appears; after pmem_resp the buffer is empty.
- Fill to DEPTH with a stalled pmem (pmem_resp held low), then write 0x4000 → no mem_resp until the first pmem_resp; the write is accepted the following cycle.
- Write 0x2000 = A, write 0x2000 = B, read 0x2008 → mem_rdata = B at latency 1, with no pmem_read.
- Read miss 0x5550 during DRAIN of 0x1230 → pmem_read is asserted only after the drain's pmem_resp plus one IDLE cycle; mem_rdata = pmem_rdata.
- Assert reset during FILL → pmem_read = 0 the next cycle, mem_resp never pulses, count = 0.
